// File: rtl/coproc_pkg.sv
// coproc_pkg: shared opcodes, matrix width and arbiter FSM encoding for the coprocessor arbiter
package coproc_pkg;
  localparam int MAT_W = 200;
  localparam logic [2:0] OP_CONV = 3'b101;
  localparam logic [2:0] OP_RST = 3'b111;
  typedef enum logic [2:0] {ST_FLUSH, ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/arbitro_rr2.sv
// arbitro_rr2: combinational 2-way round-robin pick; req[1:0] valid requests, last = port granted last time, gnt[1:0] one-hot winner
module arbitro_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = (req[0] && (last || !req[1])) ? 2'b01 : req[1] ? 2'b10 : 2'b00;
  end
endmodule

// File: rtl/arbitro_coprocessador.sv
// arbitro_coprocessador: round-robin sharing of one coprocessor between two requesters.
// Requester side: req_valid/req_ready handshake with op, size and two operand matrices per port.
// Coprocessor side: latched cp_op/cp_tamanho/cp_matriz1/2 with a one-cycle cp_start; result captured on cp_done.
// Response side: resp_valid/resp_ready to the granted port with shared resp_matriz/resp_overflow/resp_err.
// Optional ARB_TIMEOUT_EN: watchdog in WAIT that aborts with resp_err = 1 and a zero result.
module arbitro_coprocessador #(
  parameter int MAT_W = coproc_pkg::MAT_W,
  parameter int FLUSH_CYC = 3,
  parameter int TMO_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op_0,
  input  logic [2:0]       req_op_1,
  input  logic [2:0]       req_tam_0,
  input  logic [2:0]       req_tam_1,
  input  logic [MAT_W-1:0] req_m1_0,
  input  logic [MAT_W-1:0] req_m1_1,
  input  logic [MAT_W-1:0] req_m2_0,
  input  logic [MAT_W-1:0] req_m2_1,
  output logic             cp_start,
  output logic [2:0]       cp_op,
  output logic [2:0]       cp_tamanho,
  output logic [MAT_W-1:0] cp_matriz1,
  output logic [MAT_W-1:0] cp_matriz2,
  input  logic [MAT_W-1:0] cp_result,
  input  logic             cp_overflow,
  input  logic             cp_done,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [MAT_W-1:0] resp_matriz,
  output logic             resp_overflow,
  output logic             resp_err
);
  import coproc_pkg::*;
  localparam int CW = $clog2(TMO_CYC > FLUSH_CYC ? TMO_CYC : FLUSH_CYC) + 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic rr_last, grant, take, ack, tmo, cnt_run, fin;
  logic [1:0] pick;
  arbitro_rr2 u_rr (.req(req_valid), .last(rr_last), .gnt(pick));
  assign req_ready = (state == ST_IDLE) ? pick : 2'b00;
  assign take = |req_ready;
  assign cp_start = state == ST_ISSUE;
  assign resp_valid = (state == ST_RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign ack = state == ST_RESP && resp_ready[grant];
  assign fin = state == ST_WAIT && (cp_done || tmo);
`ifdef ARB_TIMEOUT_EN
  assign tmo = state == ST_WAIT && cnt == CW'(TMO_CYC - 1);
  assign cnt_run = state == ST_FLUSH || state == ST_WAIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) resp_err <= 1'b0;
    else if (fin) resp_err <= !cp_done;
`else
  assign tmo = 1'b0;
  assign cnt_run = state == ST_FLUSH;
  assign resp_err = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      ST_FLUSH: nxt = (cnt == CW'(FLUSH_CYC - 1)) ? ST_IDLE : ST_FLUSH;
      ST_IDLE:  nxt = take ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: nxt = ST_WAIT;
      ST_WAIT:  nxt = fin ? ST_RESP : ST_WAIT;
      ST_RESP:  nxt = ack ? ST_IDLE : ST_RESP;
      default:  nxt = ST_FLUSH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_FLUSH;
      cnt <= '0;
      rr_last <= 1'b1;
      grant <= 1'b0;
      cp_op <= '0;
      cp_tamanho <= '0;
      cp_matriz1 <= '0;
      cp_matriz2 <= '0;
      resp_matriz <= '0;
      resp_overflow <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (cnt_run && nxt == state) ? cnt + 1'b1 : '0;
      if (take) begin
        grant <= req_ready[1];
        rr_last <= req_ready[1];
        cp_op <= req_ready[1] ? req_op_1 : req_op_0;
        cp_tamanho <= req_ready[1] ? req_tam_1 : req_tam_0;
        cp_matriz1 <= req_ready[1] ? req_m1_1 : req_m1_0;
        cp_matriz2 <= req_ready[1] ? req_m2_1 : req_m2_0;
      end
      if (fin) begin
        resp_matriz <= cp_done ? cp_result : '0;
        resp_overflow <= cp_done && cp_overflow;
      end
    end
endmodule

// File: tb/tb_arbitro_coprocessador.sv
// tb_arbitro_coprocessador: self-checking bench for arbitro_coprocessador with a 3-cycle coprocessor model
module tb_arbitro_coprocessador;
  import coproc_pkg::*;
  localparam int W = MAT_W;
  localparam int FL = 3;
  localparam int TMO = 64;
  logic clk = 0, rst_n = 0;
  logic [1:0] req_valid = 0, req_ready, resp_valid, resp_ready = 0;
  logic [2:0] req_op_0 = 0, req_op_1 = 0, req_tam_0 = 0, req_tam_1 = 0, cp_op, cp_tamanho;
  logic [W-1:0] req_m1_0 = 0, req_m1_1 = 0, req_m2_0 = 0, req_m2_1 = 0;
  logic [W-1:0] cp_matriz1, cp_matriz2, cp_result, resp_matriz;
  logic cp_start, cp_overflow, cp_done, resp_overflow, resp_err;
  logic model_en = 1, model_done = 0, spur = 0;
  int md = 0;
  int ntests = 0, nfail = 0;
  typedef struct {
    logic p;
    logic [2:0] op;
    logic [2:0] tam;
    logic [W-1:0] m1;
    logic [W-1:0] m2;
    logic [W-1:0] res;
    logic ov;
    int hold;
  } vec_t;
  vec_t tbl[4];
  arbitro_coprocessador #(.MAT_W(W), .FLUSH_CYC(FL), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_0(req_op_0), .req_op_1(req_op_1), .req_tam_0(req_tam_0), .req_tam_1(req_tam_1),
    .req_m1_0(req_m1_0), .req_m1_1(req_m1_1), .req_m2_0(req_m2_0), .req_m2_1(req_m2_1),
    .cp_start(cp_start), .cp_op(cp_op), .cp_tamanho(cp_tamanho),
    .cp_matriz1(cp_matriz1), .cp_matriz2(cp_matriz2), .cp_result(cp_result),
    .cp_overflow(cp_overflow), .cp_done(cp_done), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_matriz(resp_matriz), .resp_overflow(resp_overflow),
    .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  assign cp_done = model_done | spur;
  assign cp_result = model_done ? (cp_matriz1 ^ cp_matriz2) : '0;
  assign cp_overflow = model_done && cp_op == OP_CONV && cp_matriz1[0];
  always @(negedge clk) begin
    model_done = 1'b0;
    if (md > 0) begin
      md--;
      if (md == 0) model_done = model_en;
    end
    if (cp_start) md = 3;
  end
  task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic wait_grant(input logic [1:0] g);
    int i;
    #1;
    for (i = 0; i < 20 && req_ready == 2'b00; i++) begin
      @(negedge clk);
      #1;
    end
    chk("grant", W'(req_ready), W'(g));
  endtask
  task automatic txn(input logic p, input logic [2:0] op, input logic [2:0] tam,
                     input logic [W-1:0] m1, input logic [W-1:0] m2, input logic [W-1:0] res,
                     input logic ov, input int hold, input logic keep);
    logic [1:0] g;
    g = p ? 2'b10 : 2'b01;
    if (p) begin
      req_op_1 = op; req_tam_1 = tam; req_m1_1 = m1; req_m2_1 = m2;
    end else begin
      req_op_0 = op; req_tam_0 = tam; req_m1_0 = m1; req_m2_0 = m2;
    end
    req_valid[p] = 1'b1;
    wait_grant(g);
    @(negedge clk);
    if (!keep) req_valid[p] = 1'b0;
    #1;
    chk("start", W'(cp_start), W'(1'b1));
    chk("cp_op", W'(cp_op), W'(op));
    chk("cp_tam", W'(cp_tamanho), W'(tam));
    chk("cp_m1", cp_matriz1, m1);
    chk("cp_m2", cp_matriz2, m2);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      #1;
      chk("wait quiet", W'({resp_valid, cp_start}), '0);
    end
    chk("m1 held", cp_matriz1, m1);
    @(negedge clk);
    #1;
    chk("resp_valid", W'(resp_valid), W'(g));
    chk("resp_matriz", resp_matriz, res);
    chk("resp_ov", W'(resp_overflow), W'(ov));
    chk("resp_err", W'(resp_err), '0);
    resp_ready = ~g;
    if (hold > 0) req_valid[!p] = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("bp valid", W'(resp_valid), W'(g));
      chk("bp matriz", resp_matriz, res);
      chk("bp no grant", W'(req_ready), '0);
    end
    if (hold > 0) req_valid[!p] = 1'b0;
    resp_ready = g;
    @(negedge clk);
    #1;
    chk("resp taken", W'(resp_valid), '0);
    resp_ready = 2'b00;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst ctl", W'({req_ready, cp_start, cp_op, cp_tamanho, resp_valid, resp_overflow, resp_err}), '0);
    chk("rst m1", cp_matriz1, '0);
    chk("rst m2", cp_matriz2, '0);
    chk("rst resp", resp_matriz, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < FL; k++) begin
      chk("flush quiet", W'({req_ready, resp_valid, cp_start}), '0);
      @(negedge clk);
      #1;
    end
    if (req_valid[0]) chk("first grant", W'(req_ready), W'(2'b01));
  endtask
  initial begin
    tbl[0] = '{1'b0, OP_CONV, 3'd4, {25{8'hA5}}, {25{8'h0F}}, {25{8'hAA}}, 1'b1, 0};
    tbl[1] = '{1'b1, OP_RST, 3'd2, {25{8'h3C}}, {25{8'hFF}}, {25{8'hC3}}, 1'b0, 0};
    tbl[2] = '{1'b0, OP_CONV, 3'd3, {25{8'h12}}, {25{8'h34}}, {25{8'h26}}, 1'b0, 10};
    tbl[3] = '{1'b1, OP_CONV, 3'd5, {25{8'h01}}, {W{1'b0}}, {25{8'h01}}, 1'b1, 2};
    req_op_1 = OP_RST;
    req_m1_1 = {25{8'h55}};
    req_valid = 2'b11;
    do_reset();
    txn(1'b0, OP_CONV, 3'd4, {25{8'h81}}, {25{8'h01}}, {25{8'h80}}, 1'b1, 0, 1'b1);
    txn(1'b1, OP_RST, 3'd2, {25{8'h55}}, {25{8'hAA}}, {25{8'hFF}}, 1'b0, 0, 1'b1);
    txn(1'b0, OP_CONV, 3'd3, {25{8'h40}}, {25{8'h04}}, {25{8'h44}}, 1'b0, 0, 1'b1);
    txn(1'b1, OP_CONV, 3'd5, {25{8'hF1}}, {25{8'h0F}}, {25{8'hFE}}, 1'b1, 0, 1'b1);
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++)
      txn(tbl[k].p, tbl[k].op, tbl[k].tam, tbl[k].m1, tbl[k].m2, tbl[k].res, tbl[k].ov, tbl[k].hold, 1'b0);
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("spurious done", W'({resp_valid, req_ready, cp_start}), '0);
      @(negedge clk);
    end
    txn(1'b1, OP_CONV, 3'd3, {25{8'h0C}}, {25{8'hC0}}, {25{8'hCC}}, 1'b0, 0, 1'b0);
    req_op_0 = OP_CONV;
    req_tam_0 = 3'd5;
    req_m1_0 = {25{8'h77}};
    req_m2_0 = {25{8'h70}};
    req_valid = 2'b01;
    wait_grant(2'b01);
    @(negedge clk);
    #1;
    chk("t4 start", W'(cp_start), W'(1'b1));
    do_reset();
    txn(1'b0, OP_CONV, 3'd5, {25{8'h77}}, {25{8'h70}}, {25{8'h07}}, 1'b1, 0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    model_en = 1'b0;
    req_m1_0 = {25{8'h99}};
    req_valid = 2'b01;
    wait_grant(2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    for (int c = 2; c <= TMO + 1; c++) @(negedge clk);
    #1;
    chk("tmo pending", W'(resp_valid), '0);
    @(negedge clk);
    #1;
    chk("tmo valid", W'(resp_valid), W'(2'b01));
    chk("tmo err", W'(resp_err), W'(1'b1));
    chk("tmo matriz", resp_matriz, '0);
    chk("tmo ov", W'(resp_overflow), '0);
    resp_ready = 2'b01;
    @(negedge clk);
    #1;
    chk("tmo taken", W'(resp_valid), '0);
    resp_ready = 2'b00;
    model_en = 1'b1;
    txn(1'b1, OP_CONV, 3'd4, {25{8'h21}}, {25{8'h12}}, {25{8'h33}}, 1'b1, 0, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", nfail);
    $fatal(1);
  end
endmodule
